// File: rtl/hy_pipe_top.sv
// hy_pipe_top: programmable single-rule packet parser on the 134-bit packet bus.
//
// In-band configuration packets (head word 6 == 0x9006) program the rule
// tables and are dropped. Every other packet is written into an output FIFO
// as it arrives. When its deciding beat (second beat, or the head of a
// single-beat packet) is accepted, the packet is classified and up to eight
// 16-bit key fields are extracted. The packet then leaves as one metadata
// beat {01, 000, match, key} followed by the original beats. The original
// head tag is rewritten to 00.
//
// Ports:
//   i_clk          clock
//   i_rst_n        synchronous active-low reset
//   i_data_valid   input beat valid (no backpressure)
//   i_data[133:0]  {tag[1:0], valid nibble[3:0], data[127:0]}; word 0 = [127:112]
//   o_data_valid   output beat valid
//   o_data[133:0]  output beat, same format

module syncfifo #(
  parameter int WIDTH = 134,
  parameter int DEPTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // show-ahead read: the oldest word is always presented
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module hy_pipe_top (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_data_valid,
  input  logic [133:0] i_data,
  output logic         o_data_valid,
  output logic [133:0] o_data
);
  localparam int          NKEY      = 8;
  localparam logic [15:0] CFG_ETYPE = 16'h9006;

  typedef enum logic [1:0] {S_IDLE, S_CFG, S_NORM1, S_NORM} in_state_t;
  typedef enum logic       {O_META, O_STREAM} out_state_t;

  // rule tables
  logic [3:0]  type_off [2];
  logic [15:0] type_val [2];
  logic [15:0] type_msk [2];
  logic [3:0]  key_off  [16];
  logic        rule_en;

  logic         cfg_we, cfg_we_q;
  logic [31:0]  cfg_addr_q, cfg_data_q;
  in_state_t    st, st_nxt;
  logic         fifo_wr, decide;
  logic [1:0]   in_tag;
  logic [127:0] head_q;

  assign in_tag = i_data[133:132];

  // Input classifier. A head always restarts classification so a lost tail
  // cannot wedge the parser in a stale packet.
  always_comb begin
    st_nxt  = st;
    fifo_wr = 1'b0;
    decide  = 1'b0;
    cfg_we  = 1'b0;
    if (i_data_valid) begin
      if (in_tag[0]) begin
        if (i_data[31:16] == CFG_ETYPE) begin
          st_nxt = in_tag[1] ? S_IDLE : S_CFG;
        end else begin
          fifo_wr = 1'b1;
          decide  = in_tag[1];      // single-beat packet decides on its head
          st_nxt  = in_tag[1] ? S_IDLE : S_NORM1;
        end
      end else begin
        case (st)
          S_CFG:   cfg_we = (i_data[131:128] == 4'hf);
          S_NORM1: begin fifo_wr = 1'b1; decide = 1'b1; end
          S_NORM:  fifo_wr = 1'b1;
          default: ;                // stray beat outside a packet
        endcase
        if (in_tag[1])             st_nxt = S_IDLE;
        else if (st == S_NORM1)    st_nxt = S_NORM;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      st         <= S_IDLE;
      cfg_we_q   <= 1'b0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
      head_q     <= '0;
    end else begin
      st       <= st_nxt;
      cfg_we_q <= cfg_we;
      if (cfg_we) begin
        cfg_addr_q <= i_data[47:16];
        cfg_data_q <= i_data[79:48];
      end
      if (i_data_valid && in_tag[0]) head_q <= i_data[127:0];
    end
  end

  // Writes land one cycle after acceptance, so a same-cycle lookup sees the
  // old table contents.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rule_en <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        type_off[s] <= '0;
        type_val[s] <= '0;
        type_msk[s] <= '0;
      end
      for (int k = 0; k < 16; k++) key_off[k] <= '0;
    end else if (cfg_we_q) begin
      if (cfg_addr_q[31:1] == 31'h0) begin
        type_off[cfg_addr_q[0]] <= cfg_data_q[3:0];
      end else if (cfg_addr_q[31:16] == 16'h0001) begin
        case (cfg_addr_q[15:8])
          8'h00: if (cfg_addr_q[7:0] == 8'h02) rule_en <= cfg_data_q[0];
          8'h01: if (cfg_addr_q[7:1] == 7'h0) begin
                   type_val[cfg_addr_q[0]] <= cfg_data_q[31:16];
                   type_msk[cfg_addr_q[0]] <= cfg_data_q[15:0];
                 end
          8'h02: if (cfg_addr_q[7:4] == 4'h0) key_off[cfg_addr_q[3:0]] <= cfg_data_q[3:0];
          default: ;
        endcase
      end
    end
  end

  // 16 words: 0..7 from the head, 8..15 from the second beat (zero if none)
  logic [255:0] words;
  assign words = in_tag[0] ? {i_data[127:0], 128'h0} : {head_q, i_data[127:0]};

  function automatic logic [15:0] word_sel(input logic [255:0] w, input logic [3:0] idx);
    return w[{~idx, 4'hf} -: 16];   // 255 - 16*idx
  endfunction

  logic [1:0] t_ok;
  for (genvar s = 0; s < 2; s++) begin : g_type
    assign t_ok[s] = ((word_sel(words, type_off[s]) ^ type_val[s]) & type_msk[s]) == 16'h0;
  end

  logic [NKEY-1:0][15:0] key_fld;
  for (genvar k = 0; k < NKEY; k++) begin : g_key
    assign key_fld[NKEY-1-k] = word_sel(words, key_off[k]);   // key field 0 in the MSBs
  end

  logic         match;
  logic [127:0] key;
  assign match = rule_en & (&t_ok);
  assign key   = match ? key_fld : 128'h0;

  // Pending metadata, one entry per decided packet, in arrival order.
  logic [128:0] mq [4];
  logic [2:0]   mq_wp, mq_rp;
  logic         mq_empty, mq_full, mq_pop;
  assign mq_empty = (mq_wp == mq_rp);
  assign mq_full  = (mq_wp[2] != mq_rp[2]) && (mq_wp[1:0] == mq_rp[1:0]);

  always_ff @(posedge i_clk) begin
    if (decide && !mq_full) mq[mq_wp[1:0]] <= {match, key};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mq_wp <= '0;
      mq_rp <= '0;
    end else begin
      if (decide && !mq_full) mq_wp <= mq_wp + 3'd1;
      if (mq_pop)             mq_rp <= mq_rp + 3'd1;
    end
  end

  logic         fifo_rd, fifo_empty, fifo_full;
  logic [133:0] fifo_q;

  syncfifo #(.WIDTH(134), .DEPTH(128)) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (fifo_wr && !fifo_full),
    .wr_data (i_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_q),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // Output sequencer: one metadata beat, then stream FIFO beats up to the tail.
  out_state_t   ost, ost_nxt;
  logic         out_vld_nxt;
  logic [133:0] out_nxt;

  always_comb begin
    ost_nxt     = ost;
    mq_pop      = 1'b0;
    fifo_rd     = 1'b0;
    out_vld_nxt = 1'b0;
    out_nxt     = '0;
    case (ost)
      O_META: if (!mq_empty) begin
        mq_pop      = 1'b1;
        out_vld_nxt = 1'b1;
        out_nxt     = {2'b01, 3'b000, mq[mq_rp[1:0]]};
        ost_nxt     = O_STREAM;
      end
      O_STREAM: if (!fifo_empty) begin
        fifo_rd     = 1'b1;
        out_vld_nxt = 1'b1;
        out_nxt     = {fifo_q[133], 1'b0, fifo_q[131:0]};   // head flag cleared
        if (fifo_q[133]) ost_nxt = O_META;
      end
      default: ost_nxt = O_META;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ost          <= O_META;
      o_data_valid <= 1'b0;
      o_data       <= '0;
    end else begin
      ost          <= ost_nxt;
      o_data_valid <= out_vld_nxt;
      o_data       <= out_nxt;
    end
  end
endmodule

// File: tb/tb_hy_pipe_top.sv
// Testbench for hy_pipe_top: directed scenarios followed by randomized
// rule/packet pairs, checked against a behavioural model of the tables.
module tb_hy_pipe_top;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_data_valid = 1'b0;
  logic [133:0] i_data = '0;
  logic         o_data_valid;
  logic [133:0] o_data;

  hy_pipe_top dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_data_valid (o_data_valid),
    .o_data       (o_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  logic [3:0]  m_toff [2];
  logic [15:0] m_val  [2];
  logic [15:0] m_msk  [2];
  logic [3:0]  m_koff [16];
  bit          m_en;

  logic [133:0] pkt  [$];
  logic [133:0] npkt [$];
  logic [133:0] exp_d [$];
  int           exp_c [$];
  logic [133:0] mon_d [$];
  int           mon_c [$];
  logic [133:0] last_meta;

  always @(negedge clk) begin
    if (rst_n && o_data_valid) begin
      mon_d.push_back(o_data);
      mon_c.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset();
    m_en = 1'b0;
    for (int s = 0; s < 2; s++) begin m_toff[s] = '0; m_val[s] = '0; m_msk[s] = '0; end
    for (int k = 0; k < 16; k++) m_koff[k] = '0;
  endfunction

  function automatic void mdl_write(input logic [31:0] addr, input logic [31:0] data);
    if (addr <= 32'd1) m_toff[addr] = data[3:0];
    else if (addr == 32'h0001_0002) m_en = data[0];
    else if (addr == 32'h0001_0100 || addr == 32'h0001_0101) begin
      m_val[addr - 32'h0001_0100] = data[31:16];
      m_msk[addr - 32'h0001_0100] = data[15:0];
    end else if (addr >= 32'h0001_0200 && addr <= 32'h0001_020f)
      m_koff[addr - 32'h0001_0200] = data[3:0];
  endfunction

  function automatic logic [15:0] pkt_word(input int idx);
    if (idx < 8) return pkt[0][127-16*idx -: 16];
    if (pkt.size() > 1) return pkt[1][127-16*(idx-8) -: 16];
    return 16'h0;
  endfunction

  function automatic logic [128:0] mdl_meta();
    bit           ok;
    logic [127:0] k;
    ok = m_en;
    for (int s = 0; s < 2; s++)
      if ((pkt_word(int'(m_toff[s])) & m_msk[s]) != (m_val[s] & m_msk[s])) ok = 0;
    k = '0;
    if (ok) for (int f = 0; f < 8; f++) k[127-16*f -: 16] = pkt_word(int'(m_koff[f]));
    return {ok, k};
  endfunction

  task automatic add_beat(input logic [1:0] tag, input logic [3:0] nib, input logic [127:0] d);
    pkt.push_back({tag, nib, d});
  endtask

  // drive pkt back-to-back, then one idle cycle; normal packets queue expectations
  task automatic send_pkt(input bit normal);
    logic [128:0] m;
    int           dc;
    dc = 0;
    m  = normal ? mdl_meta() : '0;
    foreach (pkt[i]) begin
      @(posedge clk); #1;
      i_data_valid = 1'b1;
      i_data       = pkt[i];
      if (i == ((pkt.size() > 1) ? 1 : 0)) dc = cyc;
      if (!normal && i > 0 && pkt[i][131:128] == 4'hf) mdl_write(pkt[i][47:16], pkt[i][79:48]);
    end
    @(posedge clk); #1;
    i_data_valid = 1'b0;
    i_data       = '0;
    if (normal) begin
      exp_d.push_back({2'b01, 3'b000, m});
      exp_c.push_back(dc + 2);
      foreach (pkt[i]) begin
        exp_d.push_back({(i == pkt.size()-1) ? 2'b10 : 2'b00, pkt[i][131:0]});
        exp_c.push_back(dc + 3 + i);
      end
    end
    pkt.delete();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (mon_d.size() < exp_d.size() && t < 200) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    #1;
    check_int("beat_count", mon_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < mon_d.size()) begin
        check("beat_data", mon_d[i], exp_d[i]);
        check_int("beat_cycle", mon_c[i], exp_c[i]);
        if (exp_d[i][133:132] == 2'b01) last_meta = mon_d[i];
      end
    end
    exp_d.delete(); exp_c.delete(); mon_d.delete(); mon_c.delete();
  endtask

  task automatic cfg_begin();
    pkt.delete();
    add_beat(2'b01, 4'hf, {96'h1234_5678_9abc_def0_1111_2222, 16'h9006, 16'h0});
  endtask

  task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] nib = 4'hf);
    add_beat(2'b00, nib, {48'h0, data, addr, 16'h0});
  endtask

  task automatic send_cfg();
    pkt[pkt.size()-1][133:132] = 2'b10;
    send_pkt(0);
    repeat (4) @(posedge clk);
    #1;
    check_int("cfg_consumed", mon_d.size(), 0);
    mon_d.delete(); mon_c.delete();
  endtask

  task automatic plan_cfg(input logic [15:0] v0);
    cfg_begin();
    cfg_wr(32'h0, 32'd1);
    cfg_wr(32'h1, 32'd3);
    cfg_wr(32'h0001_0100, {v0, 16'h00ff});
    cfg_wr(32'h0001_0101, 32'h0);
    for (int i = 0; i < 8; i++) cfg_wr(32'h0001_0200 + i, i + 1);
    cfg_wr(32'h0001_0209, 32'd5);
    cfg_wr(32'h0001_0002, 32'd1);
    cfg_wr(32'h0001_0002, 32'd0, 4'h7);      // partial nibble: ignored
    cfg_wr(32'h0000_0002, 32'd5);            // unmapped
    cfg_wr(32'h0001_0210, 32'hf);            // unmapped
    cfg_wr(32'h0001_0102, 32'hffff_ffff);    // unmapped
    send_cfg();
  endtask

  task automatic plan_pkt();
    pkt.delete();
    add_beat(2'b01, 4'hf, 128'h0001_0203_0405_0607_0809_0a0b_0800_4500);
    for (int i = 1; i <= 4; i++) add_beat((i == 4) ? 2'b10 : 2'b00, 4'hf, 128'(i));
  endtask

  localparam logic [133:0] META_ZERO  = {2'b01, 4'h0, 128'h0};
  localparam logic [133:0] META_MATCH = {2'b01, 4'h1, 128'h0203_0405_0607_0809_0a0b_0800_4500_0000};

  initial begin
    int           len;
    logic [127:0] d;
    logic [3:0]   to0, to1;
    logic [15:0]  v0, v1, k0, k1;
    mdl_reset();
    // reset state
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_valid", {133'h0, o_data_valid}, 134'h0);
      check("rst_data", o_data, 134'h0);
    end
    rst_n = 1'b1;
    // fresh tables: no match, zero key
    plan_pkt(); send_pkt(1); drain();
    check("fresh_meta", last_meta, META_ZERO);
    // no match
    plan_cfg(16'h0001);
    plan_pkt(); send_pkt(1); drain();
    check("nomatch_meta", last_meta, META_ZERO);
    // match
    plan_cfg(16'h0003);
    plan_pkt(); send_pkt(1); drain();
    check("match_meta", last_meta, META_MATCH);
    // two packets, one idle cycle apart
    plan_pkt(); send_pkt(1);
    plan_pkt(); send_pkt(1);
    drain();
    check("pair_meta", last_meta, META_MATCH);
    // disable
    cfg_begin(); cfg_wr(32'h0001_0002, 32'd0); send_cfg();
    plan_pkt(); send_pkt(1); drain();
    check("disable_meta", last_meta, META_ZERO);
    // re-enable, then reset mid-packet
    cfg_begin(); cfg_wr(32'h0001_0002, 32'd1); send_cfg();
    plan_pkt();
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; i_data_valid = 1'b1; i_data = pkt[i]; end
    @(posedge clk); #1;
    i_data_valid = 1'b0; i_data = '0; rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("midrst_valid", {133'h0, o_data_valid}, 134'h0);
      check("midrst_data", o_data, 134'h0);
    end
    rst_n = 1'b1;
    mdl_reset();
    mon_d.delete(); mon_c.delete();
    repeat (10) @(posedge clk);
    #1;
    check_int("rst_flush", mon_d.size(), 0);
    plan_pkt(); send_pkt(1); drain();
    check("post_reset_meta", last_meta, META_ZERO);
    // random rules and packets
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(2, 6);
      pkt.delete();
      for (int b = 0; b < len; b++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        if (b == 0 && d[31:16] == 16'h9006) d[31:16] = 16'h0800;
        add_beat((b == 0) ? 2'b01 : ((b == len-1) ? 2'b10 : 2'b00),
                 (b == len-1) ? 4'($urandom_range(1, 15)) : 4'hf, d);
      end
      to0 = 4'($urandom_range(0, 15));
      to1 = 4'($urandom_range(0, 15));
      k0  = 16'($urandom);
      k1  = 16'($urandom);
      v0  = ($urandom_range(0, 3) != 0) ? pkt_word(int'(to0)) : 16'($urandom);
      v1  = ($urandom_range(0, 3) != 0) ? pkt_word(int'(to1)) : 16'($urandom);
      npkt = pkt;
      cfg_begin();
      cfg_wr(32'h0, {28'h0, to0});
      cfg_wr(32'h1, {28'h0, to1});
      cfg_wr(32'h0001_0100, {v0, k0});
      cfg_wr(32'h0001_0101, {v1, k1});
      for (int k = 0; k < 8; k++) cfg_wr(32'h0001_0200 + k, $urandom_range(0, 15));
      cfg_wr(32'h0001_0002, ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
      send_cfg();
      pkt = npkt;
      send_pkt(1);
      drain();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
